// File: rtl/arb_cycle_walker_if.sv
// Bus bundle for the cycle walker: vertmat read port plus the path stream.
// master = walker side, slave = memory / consumer side.
interface arb_cycle_walker_if #(
  parameter int PW = 2,
  parameter int WW = 32
);
  logic [PW-1:0]    vertmat_addr;
  logic [PW+WW-1:0] vertmat_q;
  logic             path_valid;
  logic             path_ready;
  logic [PW-1:0]    path_vertex;
  logic             path_last;

  modport master (
    output vertmat_addr,
    input  vertmat_q,
    output path_valid,
    input  path_ready,
    output path_vertex,
    output path_last
  );

  modport slave (
    input  vertmat_addr,
    output vertmat_q,
    input  path_valid,
    output path_ready,
    input  path_vertex,
    input  path_last
  );
endinterface

// File: rtl/arb_cycle_walker.sv
// Arbitrage cycle walker: follows predecessor pointers from a chosen vertex for
// NODES hops (guaranteeing it lands on a cycle if one is reachable), then
// streams that cycle starting at the landing (anchor) vertex.
`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 31
`endif

module arb_cycle_walker #(
  parameter int             NODES = `NODES,
  parameter int             PW    = `PRED_WIDTH + 1,
  parameter int             WW    = `WEIGHT_WIDTH + 1,
  parameter logic [WW-1:0]  INF   = 'h777fffff
) (
  input  logic              clk,
  input  logic              walker_reset,
  input  logic              bellman_done,
  input  logic              start,
  input  logic [PW-1:0]     start_vertex,
  input  logic [PW-1:0]     src,
  arb_cycle_walker_if.master bus,
  output logic              walker_done,
  output logic              cycle_found,
  output logic [PW:0]       cycle_len,
  output logic              walker_busy
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EVAL, S_EMIT, S_DONE} state_t;
  typedef enum logic {PH_SEEK, PH_EMIT} phase_t;

  localparam logic [PW:0] NODES_W = (PW+1)'(NODES);

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] nxt_q, nxt_d;
  logic [PW-1:0] anchor_q, anchor_d;
  logic [PW-1:0] addr_q, addr_d;
  logic [PW-1:0] pvert_q, pvert_d;
  logic [PW:0]   hops_q, hops_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [PW:0]   len_q, len_d;
  logic          pvalid_q, pvalid_d;
  logic          plast_q, plast_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] q_pred;
  logic [WW-1:0] q_weight;
  logic [PW:0]   hops_inc;
  logic [PW:0]   cnt_inc;
  logic          accept;

  assign q_pred   = bus.vertmat_q[PW+WW-1:WW];
  assign q_weight = bus.vertmat_q[WW-1:0];
  assign hops_inc = hops_q + (PW+1)'(1);
  assign cnt_inc  = cnt_q + (PW+1)'(1);
  assign accept   = start && bellman_done && (state_q == S_IDLE || state_q == S_DONE);

  // Next-state and next-output computation for the walk FSM
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    anchor_d = anchor_q;
    pvert_d  = pvert_q;
    hops_d   = hops_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    pvalid_d = pvalid_q;
    plast_d  = plast_q;
    done_d   = done_q;
    found_d  = found_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          cur_d   = start_vertex;
          hops_d  = '0;
          cnt_d   = '0;
          phase_d = PH_SEEK;
          done_d  = 1'b0;
          found_d = 1'b0;
          len_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: state_d = S_EVAL;
      S_EVAL: begin
        if (phase_q == PH_SEEK) begin
          if (q_weight == INF || (cur_q == src && q_weight == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            found_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cur_d   = q_pred;
            hops_d  = hops_inc;
            state_d = S_RD;
            // After NODES hops the walk is guaranteed to sit on a cycle.
            if (hops_inc == NODES_W) begin
              anchor_d = q_pred;
              phase_d  = PH_EMIT;
            end
          end
        end else begin
          // The pointer read here tells whether cur closes the cycle, so
          // path_last is known before the beat is presented.
          nxt_d    = q_pred;
          pvalid_d = 1'b1;
          pvert_d  = cur_q;
          plast_d  = (q_pred == anchor_q);
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.path_ready) begin
          pvalid_d = 1'b0;
          plast_d  = 1'b0;
          cnt_d    = cnt_inc;
          cur_d    = nxt_q;
          if (plast_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            found_d = 1'b1;
            len_d   = cnt_inc;
            busy_d  = 1'b0;
          end else if (cnt_inc == NODES_W) begin
            // Stream ran NODES beats without closing: memory changed under us.
            state_d = S_DONE;
            done_d  = 1'b1;
            found_d = 1'b0;
            len_d   = cnt_inc;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    addr_d = (state_d == S_IDLE || state_d == S_DONE) ? '0 : cur_d;
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (walker_reset) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_SEEK;
      cur_q    <= '0;
      nxt_q    <= '0;
      anchor_q <= '0;
      addr_q   <= '0;
      pvert_q  <= '0;
      hops_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      pvalid_q <= 1'b0;
      plast_q  <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cur_q    <= cur_d;
      nxt_q    <= nxt_d;
      anchor_q <= anchor_d;
      addr_q   <= addr_d;
      pvert_q  <= pvert_d;
      hops_q   <= hops_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      pvalid_q <= pvalid_d;
      plast_q  <= plast_d;
      done_q   <= done_d;
      found_q  <= found_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.vertmat_addr = addr_q;
  assign bus.path_valid   = pvalid_q;
  assign bus.path_vertex  = pvert_q;
  assign bus.path_last    = plast_q;
  assign walker_done      = done_q;
  assign cycle_found      = found_q;
  assign cycle_len        = len_q;
  assign walker_busy      = busy_q;

endmodule

// File: tb/tb_arb_cycle_walker.sv
// Self-checking bench for arb_cycle_walker (NODES=4, PW=2, WW=32).
module tb_arb_cycle_walker;

  localparam int N    = 4;
  localparam int INFV = 'h777fffff;

  logic       clk = 1'b0;
  logic       walker_reset, bellman_done, start;
  logic [1:0] start_vertex, src;
  logic       walker_done, cycle_found, walker_busy;
  logic [2:0] cycle_len;

  arb_cycle_walker_if #(.PW(2), .WW(32)) bus_if ();

  arb_cycle_walker #(.NODES(4), .PW(2), .WW(32)) dut (
    .clk          (clk),
    .walker_reset (walker_reset),
    .bellman_done (bellman_done),
    .start        (start),
    .start_vertex (start_vertex),
    .src          (src),
    .bus          (bus_if),
    .walker_done  (walker_done),
    .cycle_found  (cycle_found),
    .cycle_len    (cycle_len),
    .walker_busy  (walker_busy)
  );

  always #5 clk = ~clk;

  // Vertex matrix RAM with 2-cycle read latency
  logic [33:0] mem [N];
  logic [1:0]  a1;
  always @(posedge clk) begin
    a1               <= bus_if.vertmat_addr;
    bus_if.vertmat_q <= mem[a1];
  end

  int total = 0;
  int bad   = 0;

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [33:0] ent(input int p, input int w);
    logic [1:0]  pp;
    logic [31:0] ww;
    pp = p[1:0];
    ww = w;
    return {pp, ww};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s, input int sv);
    src          = s[1:0];
    start_vertex = sv[1:0];
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  int'(bus_if.vertmat_addr), 0);
    check({tag, "_valid"}, int'(bus_if.path_valid), 0);
    check({tag, "_vert"},  int'(bus_if.path_vertex), 0);
    check({tag, "_last"},  int'(bus_if.path_last), 0);
    check({tag, "_done"},  int'(walker_done), 0);
    check({tag, "_found"}, int'(cycle_found), 0);
    check({tag, "_len"},   int'(cycle_len), 0);
    check({tag, "_busy"},  int'(walker_busy), 0);
  endtask

  // Stream capture. Edge n = n-th clock edge after the accepting edge.
  int got_v[$];
  int got_l[$];
  int exp_q[$];
  int fv_edge, done_edge;
  int tmo;

  // mode 0: ready high; 1: ready low 10 cycles per beat; 2: random ready
  task automatic collect(input int mode, input int budget, input int restart_at,
                         input int restart_v, input bit stop_after_first);
    int stall;
    bit hs, pstall, rdy;
    int hv, hl, pv, pl;
    got_v.delete();
    got_l.delete();
    fv_edge = -1; done_edge = -1; tmo = 1; stall = 0; pstall = 0;
    pv = 0; pl = 0;
    for (int n = 0; n < budget; n++) begin
      if (walker_done) begin
        done_edge = n;
        tmo = 0;
        break;
      end
      if (bus_if.path_valid && fv_edge < 0) fv_edge = n;
      if (pstall) begin
        check("stall_valid",  int'(bus_if.path_valid), 1);
        check("stall_vertex", int'(bus_if.path_vertex), pv);
        check("stall_last",   int'(bus_if.path_last), pl);
      end
      start        = (n == restart_at);
      start_vertex = restart_v[1:0];
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (stall >= 10);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      bus_if.path_ready = rdy;
      hs     = bus_if.path_valid && rdy;
      pstall = bus_if.path_valid && !rdy;
      if (pstall) stall++;
      hv = int'(bus_if.path_vertex);
      hl = int'(bus_if.path_last);
      pv = hv;
      pl = hl;
      tick();
      if (hs) begin
        got_v.push_back(hv);
        got_l.push_back(hl);
        stall = 0;
        if (stop_after_first) begin
          tmo = 0;
          break;
        end
      end
    end
    start = 1'b0;
    bus_if.path_ready = 1'b0;
    check("timeout", tmo, 0);
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_beats"}, got_v.size(), exp_q.size());
    n = (got_v.size() < exp_q.size()) ? got_v.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_vertex"}, got_v[k], exp_q[k]);
      check({tag, "_last"},   got_l[k], (k == exp_q.size() - 1) ? 1 : 0);
    end
  endtask

  // Reference: walk pointers N times applying the stop rules, then list the
  // cycle from the landing vertex by following pointers until it recurs.
  task automatic model(input int s, input int sv, output int fnd, output int evals);
    int cur, v, w;
    exp_q.delete();
    cur = sv; fnd = 1; evals = 0;
    for (int h = 0; h < N; h++) begin
      w = int'(mem[cur][31:0]);
      evals++;
      if (w == INFV || (cur == s && w == 0)) begin
        fnd = 0;
        break;
      end
      cur = int'(mem[cur][33:32]);
    end
    if (fnd != 0) begin
      v = cur;
      do begin
        exp_q.push_back(v);
        v = int'(mem[v][33:32]);
      end while (v != cur && exp_q.size() < N);
    end
  endtask

  typedef struct {
    logic [3:0][33:0] m;
    int               s;
    int               sv;
    int               found;
    int               nseq;
    logic [3:0][1:0]  seq;
    int               fv;
    int               de;
  } vec_t;

  vec_t vt [4];

  task automatic load_three();
    mem[0] = ent(0, 0);
    mem[1] = ent(2, -5);
    mem[2] = ent(3, -3);
    mem[3] = ent(1, -2);
  endtask

  task automatic set_exp_231();
    exp_q.delete();
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(1);
  endtask

  initial begin
    int fnd, evals;

    // three-node cycle: stream 2,3,1
    vt[0].m[0] = ent(0, 0);  vt[0].m[1] = ent(2, -5);
    vt[0].m[2] = ent(3, -3); vt[0].m[3] = ent(1, -2);
    vt[0].s = 0; vt[0].sv = 1; vt[0].found = 1; vt[0].nseq = 3;
    vt[0].seq[0] = 2; vt[0].seq[1] = 3; vt[0].seq[2] = 1; vt[0].seq[3] = 0;
    vt[0].fv = 15; vt[0].de = 24;
    // no cycle, reaches source after 3 evaluations
    vt[1].m[0] = ent(0, 0);  vt[1].m[1] = ent(0, 5);
    vt[1].m[2] = ent(1, 7);  vt[1].m[3] = ent(0, INFV);
    vt[1].s = 0; vt[1].sv = 2; vt[1].found = 0; vt[1].nseq = 0;
    vt[1].seq = '0; vt[1].fv = -1; vt[1].de = 9;
    // no cycle, unreachable start vertex
    vt[2].m = vt[1].m;
    vt[2].s = 0; vt[2].sv = 3; vt[2].found = 0; vt[2].nseq = 0;
    vt[2].seq = '0; vt[2].fv = -1; vt[2].de = 3;
    // self-loop
    vt[3].m[0] = ent(0, 0);  vt[3].m[1] = ent(1, -1);
    vt[3].m[2] = ent(0, INFV); vt[3].m[3] = ent(0, INFV);
    vt[3].s = 0; vt[3].sv = 1; vt[3].found = 1; vt[3].nseq = 1;
    vt[3].seq[0] = 1; vt[3].seq[1] = 0; vt[3].seq[2] = 0; vt[3].seq[3] = 0;
    vt[3].fv = 15; vt[3].de = 16;

    walker_reset = 1'b1; bellman_done = 1'b0; start = 1'b0;
    start_vertex = '0; src = '0; bus_if.path_ready = 1'b0;
    load_three();
    tick(); tick(); tick();
    check_reset_outputs("reset");

    // start coincident with reset: reset wins
    bellman_done = 1'b1;
    start = 1'b1; start_vertex = 2'd1;
    tick();
    start = 1'b0; walker_reset = 1'b0;
    tick();
    check("rst_wins_busy", int'(walker_busy), 0);
    check("rst_wins_addr", int'(bus_if.vertmat_addr), 0);

    // start without bellman_done is ignored
    bellman_done = 1'b0;
    do_start(0, 1);
    tick();
    check("gate_busy", int'(walker_busy), 0);
    check("gate_addr", int'(bus_if.vertmat_addr), 0);
    bellman_done = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < N; j++) mem[j] = vt[i].m[j];
      exp_q.delete();
      for (int k = 0; k < vt[i].nseq; k++) exp_q.push_back(int'(vt[i].seq[k]));
      do_start(vt[i].s, vt[i].sv);
      check("vec_busy", int'(walker_busy), 1);
      collect(0, 200, -1, 0, 1'b0);
      check("vec_found", int'(cycle_found), vt[i].found);
      check("vec_len", int'(cycle_len), vt[i].nseq);
      check("vec_first_valid", fv_edge, vt[i].fv);
      check("vec_done_edge", done_edge, vt[i].de);
      check("vec_done_busy", int'(walker_busy), 0);
      check("vec_done_addr", int'(bus_if.vertmat_addr), 0);
      check_stream("vec");
    end

    // backpressure: 10 stall cycles at every beat
    load_three();
    set_exp_231();
    do_start(0, 1);
    collect(1, 400, -1, 0, 1'b0);
    check("bp_found", int'(cycle_found), 1);
    check("bp_len", int'(cycle_len), 3);
    check_stream("bp");

    // second start while busy is ignored
    do_start(0, 1);
    collect(0, 200, 5, 3, 1'b0);
    check("busy_restart_first_valid", fv_edge, 15);
    check("busy_restart_found", int'(cycle_found), 1);
    check_stream("busy_restart");

    // start in DONE restarts the walk
    check("indone_pre_done", int'(walker_done), 1);
    do_start(0, 3);
    check("indone_done_drop", int'(walker_done), 0);
    check("indone_busy", int'(walker_busy), 1);
    exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    collect(0, 200, -1, 0, 1'b0);
    check("indone_len", int'(cycle_len), 3);
    check_stream("indone");

    // reset after the first handshake, then a fresh walk
    set_exp_231();
    do_start(0, 1);
    collect(0, 200, -1, 0, 1'b1);
    check("midrst_beats", got_v.size(), 1);
    if (got_v.size() > 0) check("midrst_first", got_v[0], 2);
    walker_reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    walker_reset = 1'b0;
    do_start(0, 1);
    collect(0, 200, -1, 0, 1'b0);
    check("midrst_found", int'(cycle_found), 1);
    check_stream("midrst_again");

    // random graphs against the reference walk
    for (int it = 0; it < 40; it++) begin
      int r, w, s, sv;
      for (int j = 0; j < N; j++) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       w = 0;
          1:       w = INFV;
          2:       w = -int'($urandom_range(1, 9));
          default: w = int'($urandom_range(1, 9));
        endcase
        mem[j] = ent(int'($urandom_range(0, 3)), w);
      end
      s  = int'($urandom_range(0, 3));
      sv = int'($urandom_range(0, 3));
      model(s, sv, fnd, evals);
      do_start(s, sv);
      bellman_done = $urandom_range(0, 1) != 0;
      collect(2, 600, -1, 0, 1'b0);
      bellman_done = 1'b1;
      check("rnd_found", int'(cycle_found), fnd);
      if (fnd != 0) begin
        check("rnd_len", int'(cycle_len), exp_q.size());
        check("rnd_first_valid", fv_edge, 3 * N + 3);
      end else begin
        check("rnd_done_edge", done_edge, 3 * evals);
      end
      check_stream("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
